// File: rtl/prog_loader_if.sv
// prog_loader_if: byte-stream input, processor memory write port and processor control of the loader
interface prog_loader_if #(
   parameter int WIDTH = 32
);
   logic             in_valid;
   logic [7:0]       in_data;
   logic             in_ready;
   logic             memEn;
   logic [WIDTH-1:0] memAddr;
   logic [WIDTH-1:0] memData;
   logic             cpu_reset;
   logic             done;
   logic             error;
   modport master (
      input  in_valid, in_data,
      output in_ready, memEn, memAddr, memData, cpu_reset, done, error
   );
   modport slave (
      output in_valid, in_data,
      input  in_ready, memEn, memAddr, memData, cpu_reset, done, error
   );
endinterface

// File: rtl/prog_loader.sv
// prog_loader: framed byte-stream loader writing a program image into processor memory
// Optional trailing XOR checksum byte is compiled in with PROG_LOADER_CHECKSUM_EN.
module prog_loader #(
   parameter int WIDTH     = 32,
   parameter int MEM_DEPTH = 16384,
   parameter int TIMEOUT   = 65535
) (
   input  logic          clock,
   input  logic          reset_n,
   prog_loader_if.master bus
);
   typedef enum logic [2:0] {
      IDLE, ADDR, LEN, CHECK, DATA,
`ifdef PROG_LOADER_CHECKSUM_EN
      CSUM,
`endif
      DONE, ERR
   } state_t;
`ifdef PROG_LOADER_CHECKSUM_EN
   localparam state_t LAST = CSUM;
`else
   localparam state_t LAST = DONE;
`endif
   localparam int TW = TIMEOUT > 1 ? $clog2(TIMEOUT + 1) : 1;
   state_t        state, nxt;
   logic [1:0]    cnt;
   logic [31:0]   base, len, k;
   logic [TW-1:0] tmo;
   logic [32:0]   span;
   logic          pend, fire, start, in_frame, tmo_hit;
`ifdef PROG_LOADER_CHECKSUM_EN
   logic [7:0]    csum;
`endif
   assign fire     = bus.in_valid && bus.in_ready;
   assign start    = fire && bus.in_data == 8'hA5 && (state == IDLE || state == DONE || state == ERR);
   assign in_frame = !(state inside {IDLE, CHECK, DONE, ERR});
   assign tmo_hit  = TIMEOUT != 0 && in_frame && !fire && 32'(tmo) + 32'd1 == 32'(TIMEOUT);
   assign span     = {1'b0, base} + {1'b0, len};
   always_ff @(posedge clock or negedge reset_n)
      if (!reset_n) state <= IDLE;
      else state <= nxt;
   always_comb begin
      nxt = state;
      case (state)
         IDLE, DONE, ERR: nxt = start ? ADDR : state;
         ADDR:  nxt = fire && cnt == 2'd3 ? LEN : ADDR;
         LEN:   nxt = fire && cnt == 2'd3 ? CHECK : LEN;
         CHECK: nxt = span > 33'(MEM_DEPTH) ? ERR : len == 32'd0 ? LAST : DATA;
         DATA:  nxt = fire && k == len - 32'd1 ? LAST : DATA;
`ifdef PROG_LOADER_CHECKSUM_EN
         CSUM:  nxt = fire ? (bus.in_data == csum ? DONE : ERR) : CSUM;
`endif
         default: nxt = IDLE;
      endcase
      if (tmo_hit) nxt = ERR;
   end
   // pend holds the processor in reset for the cycle in which the last payload write is still on the port
   always_comb begin
      bus.done      = state == DONE && !pend;
      bus.error     = state == ERR;
      bus.cpu_reset = state != DONE || pend;
   end
   always_ff @(posedge clock or negedge reset_n)
      if (!reset_n) begin
         bus.in_ready <= 1'b0;
         bus.memEn    <= 1'b0;
         bus.memAddr  <= '0;
         bus.memData  <= '0;
         cnt          <= '0;
         tmo          <= '0;
         base         <= '0;
         len          <= '0;
         k            <= '0;
         pend         <= 1'b0;
`ifdef PROG_LOADER_CHECKSUM_EN
         csum         <= '0;
`endif
      end else begin
         bus.in_ready <= nxt != CHECK;
         bus.memEn    <= fire && state == DATA;
         cnt          <= nxt != state ? 2'd0 : cnt + 2'(fire);
         tmo          <= (fire || nxt != state) ? '0 : tmo + TW'(1);
         k            <= state == DATA ? k + 32'(fire) : 32'd0;
         pend         <= state == DATA && nxt == DONE;
         if (fire && state == ADDR) base <= {bus.in_data, base[31:8]};
         if (fire && state == LEN) len <= {bus.in_data, len[31:8]};
         if (fire && state == DATA) begin
            bus.memAddr <= WIDTH'(base + k);
            bus.memData <= WIDTH'(bus.in_data);
         end
`ifdef PROG_LOADER_CHECKSUM_EN
         if (start) csum <= '0;
         else if (fire && state == DATA) csum <= csum ^ bus.in_data;
`endif
      end
endmodule

// File: tb/tb_prog_loader.sv
// tb_prog_loader: randomized and directed checks of prog_loader against a frame-level reference model
module tb_prog_loader;
   localparam int MD = 16384;
   logic clock = 1'b0;
   logic reset_n = 1'b0;
   int checks = 0;
   int fails = 0;
   logic [31:0] wa[$];
   logic [31:0] wd[$];
   prog_loader_if #(.WIDTH(32)) bus ();
   prog_loader #(.WIDTH(32), .MEM_DEPTH(MD), .TIMEOUT(8)) dut (.clock(clock), .reset_n(reset_n), .bus(bus));
   always #5 clock = ~clock;
   always @(negedge clock) if (bus.memEn) begin wa.push_back(bus.memAddr); wd.push_back(bus.memData); end
   // called at a falling edge; returns at the falling edge right after the byte transferred
   task automatic send(input logic [7:0] b);
      int n = 0;
      bus.in_valid = 1'b1;
      bus.in_data = b;
      while (!bus.in_ready && n < 16) begin @(negedge clock); n++; end
      checks++;
      if (n == 16) begin fails++; $display("FAIL send_ready in_ready=%b required 1", bus.in_ready); end
      @(negedge clock);
   endtask
   task automatic idle(input int n);
      bus.in_valid = 1'b0;
      repeat (n) @(negedge clock);
   endtask
   task automatic hdr(input logic [31:0] base, input logic [31:0] n);
      send(8'hA5);
      for (int i = 0; i < 4; i++) send(base[8*i+:8]);
      for (int i = 0; i < 4; i++) send(n[8*i+:8]);
   endtask
   task automatic test_reset;
      repeat (3) @(negedge clock);
      checks++;
      if ({bus.in_ready, bus.memEn, bus.cpu_reset, bus.done, bus.error} !== 5'b00100) begin fails++; $display("FAIL reset_ctrl got %b exp 00100", {bus.in_ready, bus.memEn, bus.cpu_reset, bus.done, bus.error}); end
      checks++;
      if ({bus.memAddr, bus.memData} !== 64'd0) begin fails++; $display("FAIL reset_bus got %h exp 0", {bus.memAddr, bus.memData}); end
      reset_n = 1'b1;
      #1;
      checks++;
      if (bus.in_ready !== 1'b0) begin fails++; $display("FAIL reset_release_ready got %b exp 0", bus.in_ready); end
      @(negedge clock);
      checks++;
      if ({bus.in_ready, bus.cpu_reset, bus.done} !== 3'b110) begin fails++; $display("FAIL reset_first_edge got %b exp 110", {bus.in_ready, bus.cpu_reset, bus.done}); end
   endtask
   task automatic test_basic;
      logic [7:0] pl[4] = '{8'h13, 8'h00, 8'h00, 8'h00};
      wa.delete(); wd.delete();
      hdr(32'h100, 32'd4);
      foreach (pl[i]) send(pl[i]);
`ifdef PROG_LOADER_CHECKSUM_EN
      send(8'h13);
      checks++;
      if ({bus.done, bus.cpu_reset} !== 2'b10) begin fails++; $display("FAIL basic_csum_release got %b exp 10", {bus.done, bus.cpu_reset}); end
`else
      checks++;
      if ({bus.memEn, bus.done, bus.cpu_reset} !== 3'b101) begin fails++; $display("FAIL basic_last_write got %b exp 101", {bus.memEn, bus.done, bus.cpu_reset}); end
      idle(1);
      checks++;
      if ({bus.memEn, bus.done, bus.cpu_reset} !== 3'b010) begin fails++; $display("FAIL basic_release got %b exp 010", {bus.memEn, bus.done, bus.cpu_reset}); end
`endif
      idle(2);
      checks++;
      if (wa.size() !== 4) begin fails++; $display("FAIL basic_count got %0d exp 4", wa.size()); end
      for (int i = 0; i < 4 && i < wa.size(); i++) begin
         checks++;
         if (wa[i] !== 32'h100 + i || wd[i] !== {24'd0, pl[i]}) begin fails++; $display("FAIL basic_write%0d got %h:%h exp %h:%h", i, wa[i], wd[i], 32'h100 + i, pl[i]); end
      end
   endtask
   task automatic test_garbage;
      wa.delete(); wd.delete();
      send(8'h00); send(8'hFF); send(8'h5A);
      idle(3);
      checks++;
      if (wa.size() !== 0 || {bus.done, bus.error, bus.cpu_reset} !== 3'b100) begin fails++; $display("FAIL garbage_ignored writes=%0d status=%b exp 0 100", wa.size(), {bus.done, bus.error, bus.cpu_reset}); end
      hdr(32'h20, 32'd2);
      send(8'hA5); send(8'h3C);
`ifdef PROG_LOADER_CHECKSUM_EN
      send(8'hA5 ^ 8'h3C);
`endif
      idle(3);
      checks++;
      if (wa.size() !== 2 || wa[0] !== 32'h20 || wd[0] !== 32'hA5 || wa[1] !== 32'h21 || wd[1] !== 32'h3C) begin fails++; $display("FAIL garbage_frame writes=%0d first=%h:%h exp 2 00000020:000000a5", wa.size(), wa[0], wd[0]); end
      checks++;
      if (bus.done !== 1'b1) begin fails++; $display("FAIL garbage_done got %b exp 1", bus.done); end
   endtask
   task automatic test_overflow;
      wa.delete(); wd.delete();
      hdr(32'h3FFE, 32'd4);
      checks++;
      if ({bus.in_ready, bus.error} !== 2'b00) begin fails++; $display("FAIL ovf_check_cycle got %b exp 00", {bus.in_ready, bus.error}); end
      @(negedge clock);
      checks++;
      if ({bus.in_ready, bus.error, bus.cpu_reset, bus.done} !== 4'b1110) begin fails++; $display("FAIL ovf_err got %b exp 1110", {bus.in_ready, bus.error, bus.cpu_reset, bus.done}); end
      send(8'h11); send(8'h22); send(8'h33); send(8'h44);
      idle(2);
      checks++;
      if (wa.size() !== 0 || bus.error !== 1'b1) begin fails++; $display("FAIL ovf_sticky writes=%0d error=%b exp 0 1", wa.size(), bus.error); end
      hdr(32'hFFFF_FFFE, 32'd4);
      idle(2);
      checks++;
      if (bus.error !== 1'b1) begin fails++; $display("FAIL ovf_wrap error=%b exp 1", bus.error); end
      hdr(32'(MD - 2), 32'd2);
      send(8'h01); send(8'h02);
`ifdef PROG_LOADER_CHECKSUM_EN
      send(8'h03);
`endif
      idle(3);
      checks++;
      if (wa.size() !== 2 || wa[1] !== 32'(MD - 1) || bus.done !== 1'b1) begin fails++; $display("FAIL ovf_edge_fit writes=%0d done=%b exp 2 1", wa.size(), bus.done); end
   endtask
   task automatic test_zero_len;
      wa.delete(); wd.delete();
      hdr(32'h80, 32'd0);
      idle(3);
`ifdef PROG_LOADER_CHECKSUM_EN
      checks++;
      if (bus.done !== 1'b0) begin fails++; $display("FAIL zero_wait_csum done=%b exp 0", bus.done); end
      send(8'h00);
      idle(2);
`endif
      checks++;
      if (wa.size() !== 0 || {bus.done, bus.error, bus.cpu_reset} !== 3'b100) begin fails++; $display("FAIL zero_len writes=%0d status=%b exp 0 100", wa.size(), {bus.done, bus.error, bus.cpu_reset}); end
   endtask
`ifdef PROG_LOADER_CHECKSUM_EN
   task automatic test_checksum;
      hdr(32'h100, 32'd4);
      send(8'h13); send(8'h00); send(8'h00); send(8'h00);
      send(8'h12);
      idle(2);
      checks++;
      if ({bus.done, bus.error, bus.cpu_reset} !== 3'b011) begin fails++; $display("FAIL csum_bad got %b exp 011", {bus.done, bus.error, bus.cpu_reset}); end
      hdr(32'h100, 32'd4);
      send(8'h13); send(8'h00); send(8'h00); send(8'h00);
      send(8'h13);
      checks++;
      if ({bus.done, bus.error, bus.cpu_reset} !== 3'b100) begin fails++; $display("FAIL csum_good got %b exp 100", {bus.done, bus.error, bus.cpu_reset}); end
   endtask
`endif
   task automatic test_random;
      for (int f = 0; f < 24; f++) begin
         int n = $urandom_range(0, 6);
         int sel = $urandom_range(0, 3);
         logic [31:0] base;
         logic [7:0] pl[$];
         logic [7:0] cs = 8'h00;
         logic ok;
         logic good = 1'b1;
         base = sel == 0 ? 32'(MD) - $urandom_range(0, 8) : sel == 1 ? 32'hFFFF_FFF8 + $urandom_range(0, 7) : $urandom_range(0, MD - 8);
         ok = longint'(base) + longint'(n) <= longint'(MD);
         for (int i = 0; i < n; i++) begin
            logic [7:0] b = $urandom_range(0, 3) == 0 ? 8'hA5 : 8'($urandom);
            pl.push_back(b);
            cs ^= b;
         end
         wa.delete(); wd.delete();
         hdr(base, 32'(n));
         if (ok) begin
            foreach (pl[i]) begin send(pl[i]); idle($urandom_range(0, 2)); end
`ifdef PROG_LOADER_CHECKSUM_EN
            good = 1'($urandom_range(0, 1));
            send(good ? cs : cs ^ 8'h01);
`endif
         end
         idle(3);
         checks++;
         if (wa.size() !== (ok ? n : 0)) begin fails++; $display("FAIL rand%0d_count got %0d exp %0d", f, wa.size(), ok ? n : 0); end
         for (int i = 0; i < wa.size() && i < n; i++) begin
            checks++;
            if (wa[i] !== base + 32'(i) || wd[i] !== {24'd0, pl[i]}) begin fails++; $display("FAIL rand%0d_write%0d got %h:%h exp %h:%h", f, i, wa[i], wd[i], base + 32'(i), pl[i]); end
         end
         checks++;
         if ({bus.done, bus.error, bus.cpu_reset} !== (ok && good ? 3'b100 : 3'b011)) begin fails++; $display("FAIL rand%0d_status got %b exp %b", f, {bus.done, bus.error, bus.cpu_reset}, ok && good ? 3'b100 : 3'b011); end
      end
   endtask
   task automatic test_timeout;
      wa.delete(); wd.delete();
      hdr(32'h40, 32'd6);
      send(8'h01); send(8'h02);
      idle(7);
      checks++;
      if (bus.error !== 1'b0) begin fails++; $display("FAIL tmo_early error=%b exp 0", bus.error); end
      idle(1);
      checks++;
      if ({bus.error, bus.cpu_reset} !== 2'b11) begin fails++; $display("FAIL tmo_hit got %b exp 11", {bus.error, bus.cpu_reset}); end
      send(8'h03); send(8'h04); send(8'h05); send(8'h06);
      idle(2);
      checks++;
      if (wa.size() !== 2) begin fails++; $display("FAIL tmo_writes got %0d exp 2", wa.size()); end
   endtask
   task automatic test_reset_mid;
      wa.delete(); wd.delete();
      hdr(32'h60, 32'd6);
      send(8'h01); send(8'h02);
      #2 reset_n = 1'b0;
      #1;
      checks++;
      if ({bus.in_ready, bus.memEn, bus.cpu_reset, bus.done, bus.error} !== 5'b00100 || {bus.memAddr, bus.memData} !== 64'd0) begin fails++; $display("FAIL rstmid_async got %b %h exp 00100 0", {bus.in_ready, bus.memEn, bus.cpu_reset, bus.done, bus.error}, {bus.memAddr, bus.memData}); end
      idle(2);
      reset_n = 1'b1;
      send(8'h03); send(8'h04);
      idle(3);
      checks++;
      if (wa.size() !== 2 || {bus.done, bus.error, bus.cpu_reset} !== 3'b001) begin fails++; $display("FAIL rstmid_after writes=%0d status=%b exp 2 001", wa.size(), {bus.done, bus.error, bus.cpu_reset}); end
   endtask
   initial begin
      bus.in_valid = 1'b0;
      bus.in_data = 8'h00;
      test_reset();
      test_basic();
      test_garbage();
      test_overflow();
      test_zero_len();
`ifdef PROG_LOADER_CHECKSUM_EN
      test_checksum();
`endif
      test_random();
      test_timeout();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end
endmodule

// File: doc/prog_loader.md
PROG_LOADER -- requirements
Module: prog_loader

Interface
REQ-001 Parameter WIDTH, 32, width of memAddr/memData.
REQ-002 Parameter MEM_DEPTH, 16384, byte capacity of target main memory.
REQ-003 Parameter TIMEOUT, 65535, max idle cycles between bytes inside a frame; 0 disables.
REQ-004 clock  input  1  sole clock, rising edge.
REQ-005 reset_n  input  1  asynchronous, active-low reset.
REQ-006 in_valid  input  1  byte-stream source has a byte.
REQ-007 in_data  input  8  stream byte.
REQ-008 in_ready  output  1  loader accepts a byte this cycle.
REQ-009 memEn  output  1  one-cycle byte-write strobe to processor memory port.
REQ-010 memAddr  output  WIDTH  byte write address.
REQ-011 memData  output  WIDTH  write data, byte in [7:0], upper bits 0.
REQ-012 cpu_reset  output  1  active-high reset driven to the processor.
REQ-013 done  output  1  level, last frame loaded, processor released.
REQ-014 error  output  1  level, last frame rejected.

Function
REQ-015 A byte transfers on a rising edge where in_valid and in_ready are both 1; no other byte is consumed.
REQ-016 Frame: sync 0xA5, 4-byte base address (little-endian), 4-byte length N (little-endian), N payload bytes, then checksum byte if enabled (REQ-034).
REQ-017 States: IDLE, ADDR, LEN, CHECK, DATA, CSUM, DONE, ERR.
REQ-018 IDLE/DONE/ERR: byte 0xA5 -> ADDR, clears done and error, sets cpu_reset=1; other bytes discarded, state unchanged.
REQ-019 ADDR after 4 bytes -> LEN; LEN after 4 bytes -> CHECK.
REQ-020 CHECK lasts exactly one cycle with in_ready=0; base+N > MEM_DEPTH (computed 33-bit, no wrap) -> ERR; N=0 -> CSUM if enabled else DONE; otherwise -> DATA.
REQ-021 in_ready=1 in every state except CHECK and during reset.
REQ-022 Payload byte k (0-based) accepted at edge t -> memEn=1, memAddr=base+k, memData={0,byte} in cycle t+1, registered; memEn=0 otherwise.
REQ-023 After payload byte N-1 -> CSUM if enabled, else DONE.
REQ-024 DONE: done=1, cpu_reset=0 from the cycle after the final memEn cycle (2 cycles after last payload byte accepted).
REQ-025 ERR: error=1, cpu_reset=1, no memEn; sticky until next accepted 0xA5.
REQ-026 Timeout: counter clears on each accepted byte and on state entry; in ADDR/LEN/DATA/CSUM, reaching TIMEOUT cycles without a transfer -> ERR.
REQ-027 A 0xA5 inside ADDR/LEN/DATA/CSUM is ordinary frame data, not a resync.
REQ-028 in_valid=0 mid-frame stalls without side effects until timeout.

Reset
REQ-029 reset_n=0 asynchronously forces state IDLE, in_ready=0, memEn=0, memAddr=0, memData=0, cpu_reset=1, done=0, error=0, counters and checksum cleared.
REQ-030 in_ready rises on the first clock edge after reset_n deasserts.
REQ-031 Reset mid-frame abandons the frame; already-issued writes are not undone.

Configuration
REQ-032 Macro PROG_LOADER_CHECKSUM_EN selects checksum support.
REQ-033 Defined: running XOR of payload bytes (initial 0x00) kept; CSUM state accepts one byte.
REQ-034 Defined: checksum match -> DONE, cpu_reset=0 the cycle after acceptance; mismatch -> ERR.
REQ-035 Undefined: no CSUM state, no checksum logic; frame ends after payload.

Verification
REQ-036 A5, 00 01 00 00, 04 00 00 00, 13 00 00 00 -> memEn 4 cycles, memAddr 0x100..0x103, memData 0x13,0,0,0; cpu_reset=0 and done=1 two cycles after last byte (no macro).
REQ-037 Bytes 00, FF, 5A before a valid frame -> no memEn, state IDLE until A5, frame then loads normally.
REQ-038 Base 0x3FFE, N=4, MEM_DEPTH=16384 -> in_ready=0 one cycle, error=1, zero memEn, cpu_reset stays 1.
REQ-039 N=0 frame -> no memEn, done=1; with macro a checksum byte 00 is required first.
REQ-040 With macro, payload 13 00 00 00 then checksum 12 -> error=1, cpu_reset=1; checksum 13 -> done=1.
REQ-041 TIMEOUT=8, stall 8 cycles in DATA -> error=1; reset_n low mid-DATA -> all outputs at reset values immediately, no further memEn.
